// File: rtl/demux_route_ctrl_if.sv
// Bus bundle for demux_route_ctrl: producer handshake, demux drive and status.
// slave = the controller, master = producer/demux side.
interface demux_route_ctrl_if #(
  parameter int DEPTH = 4
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_data;
  logic [2:0]    in_dest;
  logic [15:0]   demux_a;
  logic [2:0]    demux_sel;
  logic [7:0]    dest_we;
  logic [7:0]    dest_ack;
  logic [CW-1:0] fifo_count;
  logic          busy;
  logic          err;
  logic [2:0]    err_dest;

  modport slave (
    input  in_valid, in_data, in_dest, dest_ack,
    output in_ready, demux_a, demux_sel, dest_we, fifo_count, busy, err, err_dest
  );

  modport master (
    output in_valid, in_data, in_dest, dest_ack,
    input  in_ready, demux_a, demux_sel, dest_we, fifo_count, busy, err, err_dest
  );
endinterface

// File: rtl/demux_route_ctrl.sv
// FIFO-buffered sequencer driving a 1-to-8 demux: strobe one destination, wait for its ack.
// Optional ack timeout with error pulse is enabled by defining ROUTE_TIMEOUT_EN.
module demux_route_ctrl #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  demux_route_ctrl_if.slave rt
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, DRIVE, WAIT_ACK} state_t;

  state_t        r_state, w_next;
  logic [18:0]   r_mem [DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic [15:0]   r_demux_a;
  logic [2:0]    r_demux_sel;
  logic [7:0]    r_dest_we;
  logic [18:0]   w_head;
  logic          w_full, w_push, w_pop, w_ack, w_tmo;

  assign w_full = (r_count == CW'(DEPTH));
  assign w_push = rt.in_valid && !w_full;
  assign w_head = r_mem[r_rptr];
  assign w_ack  = rt.dest_ack[r_demux_sel];

`ifdef ROUTE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT) + 1;
  logic [TW-1:0] r_tcnt;
  logic          r_err;
  logic [2:0]    r_err_dest;

  assign w_tmo = (r_tcnt == TW'(TIMEOUT - 1));

  // Ack and timeout on the same edge: ack wins, so err only fires without ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tcnt     <= '0;
      r_err      <= 1'b0;
      r_err_dest <= '0;
    end else begin
      r_err <= 1'b0;
      if (r_state == DRIVE) begin
        r_tcnt <= '0;
      end else if (r_state == WAIT_ACK && !w_ack) begin
        if (w_tmo) begin
          r_err      <= 1'b1;
          r_err_dest <= r_demux_sel;
        end else begin
          r_tcnt <= r_tcnt + 1'b1;
        end
      end
    end
  end

  assign rt.err      = r_err;
  assign rt.err_dest = r_err_dest;
`else
  assign w_tmo       = 1'b0;
  assign rt.err      = 1'b0;
  assign rt.err_dest = 3'd0;
`endif

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_count != '0) begin
          w_pop  = 1'b1;
          w_next = DRIVE;
        end
      end
      DRIVE:    w_next = WAIT_ACK;
      WAIT_ACK: if (w_ack || w_tmo) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Storage needs no reset; emptiness is carried by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {rt.in_dest, rt.in_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Strobe is set on the pop edge so it is high for exactly the DRIVE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_demux_a   <= '0;
      r_demux_sel <= '0;
      r_dest_we   <= '0;
    end else if (w_pop) begin
      r_demux_a   <= w_head[15:0];
      r_demux_sel <= w_head[18:16];
      r_dest_we   <= 8'b1 << w_head[18:16];
    end else begin
      r_dest_we   <= '0;
    end
  end

  assign rt.in_ready   = !w_full;
  assign rt.demux_a    = r_demux_a;
  assign rt.demux_sel  = r_demux_sel;
  assign rt.dest_we    = r_dest_we;
  assign rt.fifo_count = r_count;
  assign rt.busy       = (r_state != IDLE);
endmodule
